mem_sub_ctrl: RTL and testbench

MEM_SUB_CTRL -- requirements
Module: mem_sub_ctrl

---
 rtl/mem_sub_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_sub_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sub_ctrl.sv
// CPU-side data memory controller: byte/half/word loads and stores over a
// word-wide synchronous memory, using read-modify-write for sub-word stores.
`timescale 1ns/1ps

`ifndef EXT_MEM_CWIDTH
`define EXT_MEM_CWIDTH 2
`endif
`ifndef MEM_WTYPE_WORD
`define MEM_WTYPE_WORD 2'd0
`endif
`ifndef MEM_WTYPE_HALF
`define MEM_WTYPE_HALF 2'd1
`endif
`ifndef MEM_WTYPE_BYTE
`define MEM_WTYPE_BYTE 2'd2
`endif

module mem_sub_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       iReq,
    input  logic                       iWe,
    input  logic [`EXT_MEM_CWIDTH-1:0] iType,
    input  logic                       iSigned,
    input  logic [31:0]                iAddr,
    input  logic [31:0]                iWData,
    output logic                       oReady,
    output logic                       oDone,
    output logic                       oErr,
    output logic [31:0]                oRData,
    output logic [ADDR_W-1:0]          oMemAddr,
    output logic                       oMemWe,
    output logic [31:0]                oMemWData,
    input  logic [31:0]                iMemRData
);

    typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

    state_t              state;
    logic [ADDR_W+1:0]   addr;
    logic                we;
    logic                is_half;
    logic                is_byte;
    logic                sext;
    logic [15:0]         wdata;

    logic                in_half;
    logic                in_byte;
    logic                misaligned;
    logic [7:0]          lane_b;
    logic [15:0]         lane_h;
    logic [31:0]         load_val;
    logic [31:0]         merge_val;
    logic                unused_addr_hi;

    assign unused_addr_hi = &{1'b0, iAddr[31:ADDR_W+2], iWData[31:16]};

    assign oReady   = (state == IDLE);
    assign oMemAddr = addr[ADDR_W+1:2];

    // Unknown size codes decode as WORD, so only HALF and BYTE need flags.
    assign in_half    = (iType == `MEM_WTYPE_HALF);
    assign in_byte    = (iType == `MEM_WTYPE_BYTE);
    assign misaligned = (in_half && iAddr[0]) ||
                        (!in_half && !in_byte && (iAddr[1:0] != 2'b00));

    // Lane extraction for loads and lane merge for sub-word stores share
    // the word currently returned by memory.
    always_comb begin
        lane_b    = iMemRData[7:0];
        lane_h    = addr[1] ? iMemRData[31:16] : iMemRData[15:0];
        load_val  = iMemRData;
        merge_val = iMemRData;
        case (addr[1:0])
            2'd0: lane_b = iMemRData[7:0];
            2'd1: lane_b = iMemRData[15:8];
            2'd2: lane_b = iMemRData[23:16];
            default: lane_b = iMemRData[31:24];
        endcase
        if (is_byte) begin
            load_val = {{24{sext & lane_b[7]}}, lane_b};
            case (addr[1:0])
                2'd0: merge_val[7:0]   = wdata[7:0];
                2'd1: merge_val[15:8]  = wdata[7:0];
                2'd2: merge_val[23:16] = wdata[7:0];
                default: merge_val[31:24] = wdata[7:0];
            endcase
        end else if (is_half) begin
            load_val = {{16{sext & lane_h[15]}}, lane_h};
            if (addr[1])
                merge_val[31:16] = wdata;
            else
                merge_val[15:0] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            we        <= 1'b0;
            is_half   <= 1'b0;
            is_byte   <= 1'b0;
            sext      <= 1'b0;
            wdata     <= '0;
            oDone     <= 1'b0;
            oErr      <= 1'b0;
            oMemWe    <= 1'b0;
            oMemWData <= '0;
            oRData    <= '0;
        end else begin
            oDone  <= 1'b0;
            oErr   <= 1'b0;
            oMemWe <= 1'b0;
            case (state)
                IDLE: begin
                    if (iReq) begin
                        addr    <= iAddr[ADDR_W+1:0];
                        we      <= iWe;
                        is_half <= in_half;
                        is_byte <= in_byte;
                        sext    <= iSigned;
                        wdata   <= iWData[15:0];
                        if (misaligned) begin
                            state <= DONE;
                            oDone <= 1'b1;
                            oErr  <= 1'b1;
                        end else if (iWe && !in_half && !in_byte) begin
                            state     <= WR;
                            oMemWe    <= 1'b1;
                            oMemWData <= iWData;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= RDW;
                RDW: begin
                    if (we) begin
                        state     <= WR;
                        oMemWe    <= 1'b1;
                        oMemWData <= merge_val;
                    end else begin
                        state  <= DONE;
                        oDone  <= 1'b1;
                        oRData <= load_val;
                    end
                end
                WR: begin
                    state <= DONE;
                    oDone <= 1'b1;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sub_ctrl.sv
// Directed bench for mem_sub_ctrl with a small synchronous word memory model.
`timescale 1ns/1ps

`ifndef EXT_MEM_CWIDTH
`define EXT_MEM_CWIDTH 2
`endif
`ifndef MEM_WTYPE_WORD
`define MEM_WTYPE_WORD 2'd0
`endif
`ifndef MEM_WTYPE_HALF
`define MEM_WTYPE_HALF 2'd1
`endif
`ifndef MEM_WTYPE_BYTE
`define MEM_WTYPE_BYTE 2'd2
`endif

module tb_mem_sub_ctrl;

    localparam int ADDR_W = 10;
    localparam logic [1:0] T_W = `MEM_WTYPE_WORD;
    localparam logic [1:0] T_H = `MEM_WTYPE_HALF;
    localparam logic [1:0] T_B = `MEM_WTYPE_BYTE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              iReq = 1'b0;
    logic              iWe = 1'b0;
    logic [1:0]        iType = '0;
    logic              iSigned = 1'b0;
    logic [31:0]       iAddr = '0;
    logic [31:0]       iWData = '0;
    logic              oReady;
    logic              oDone;
    logic              oErr;
    logic [31:0]       oRData;
    logic [ADDR_W-1:0] oMemAddr;
    logic              oMemWe;
    logic [31:0]       oMemWData;
    logic [31:0]       iMemRData;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en = 1'b0;
    logic [31:0]       pl_data = '0;

    int          errors = 0;
    int          checks = 0;
    int          done_cyc;
    int          we_cnt;
    int          we_cyc;
    logic [31:0] we_data;
    logic        err_seen;
    logic [31:0] addr_seen;

    mem_sub_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .iReq(iReq), .iWe(iWe), .iType(iType),
        .iSigned(iSigned), .iAddr(iAddr), .iWData(iWData), .oReady(oReady),
        .oDone(oDone), .oErr(oErr), .oRData(oRData), .oMemAddr(oMemAddr),
        .oMemWe(oMemWe), .oMemWData(oMemWData), .iMemRData(iMemRData)
    );

    always #5 clk = ~clk;

    // Word 0x10 can be preloaded by the bench; otherwise a plain sync RAM.
    always @(posedge clk) begin
        if (pl_en)
            mem[16] <= pl_data;
        else if (oMemWe)
            mem[oMemAddr] <= oMemWData;
        iMemRData <= mem[oMemAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_data = data;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] typ, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        iReq = 1'b1; iWe = we; iType = typ; iSigned = sgn; iAddr = addr; iWData = wd;
        @(posedge clk);
        #1 iReq = 1'b0;
        done_cyc = 0; we_cnt = 0; we_cyc = 0; we_data = '0; err_seen = 1'b0; addr_seen = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) addr_seen = 32'(oMemAddr);
            if (oMemWe) begin
                we_cnt++;
                we_cyc  = k;
                we_data = oMemWData;
            end
            if (oDone) begin
                done_cyc = k;
                err_seen = oErr;
                break;
            end
        end
    endtask

    initial begin
        logic        op_we   [4];
        logic [31:0] op_data [4];
        int          issued;
        int          completed;
        int          b2b_we;
        int          extra;

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 32'(oReady), 32'd1);
        checkOutput("rst_done", 32'(oDone), 32'd0);
        checkOutput("rst_err", 32'(oErr), 32'd0);
        checkOutput("rst_memwe", 32'(oMemWe), 32'd0);
        checkOutput("rst_rdata", oRData, 32'h0);

        preload(32'hAABBCCDD);

        applyStimulus(1'b0, T_B, 1'b1, 32'h43, 32'h0);
        checkOutput("lb_done_cyc", 32'(done_cyc), 32'd3);
        checkOutput("lb_memaddr", addr_seen, 32'h10);
        checkOutput("lb_err", 32'(err_seen), 32'd0);
        checkOutput("lb_rdata", oRData, 32'hFFFFFFAA);

        applyStimulus(1'b0, T_B, 1'b0, 32'h41, 32'h0);
        checkOutput("lbu_rdata", oRData, 32'h000000CC);
        applyStimulus(1'b0, T_H, 1'b1, 32'h42, 32'h0);
        checkOutput("lh_rdata", oRData, 32'hFFFFAABB);
        applyStimulus(1'b0, T_H, 1'b0, 32'h40, 32'h0);
        checkOutput("lhu_rdata", oRData, 32'h0000CCDD);
        applyStimulus(1'b0, T_W, 1'b0, 32'h40, 32'h0);
        checkOutput("lw_done_cyc", 32'(done_cyc), 32'd3);
        checkOutput("lw_rdata", oRData, 32'hAABBCCDD);

        applyStimulus(1'b1, T_B, 1'b0, 32'h41, 32'h12345611);
        checkOutput("sb_we_cnt", 32'(we_cnt), 32'd1);
        checkOutput("sb_we_cyc", 32'(we_cyc), 32'd3);
        checkOutput("sb_wdata", we_data, 32'hAABB11DD);
        checkOutput("sb_done_cyc", 32'(done_cyc), 32'd4);
        checkOutput("sb_mem", mem[16], 32'hAABB11DD);

        preload(32'hAABBCCDD);
        applyStimulus(1'b1, T_H, 1'b0, 32'h42, 32'h0000BEEF);
        checkOutput("sh_we_cnt", 32'(we_cnt), 32'd1);
        checkOutput("sh_wdata", we_data, 32'hBEEFCCDD);
        checkOutput("sh_done_cyc", 32'(done_cyc), 32'd4);

        applyStimulus(1'b1, T_W, 1'b0, 32'h40, 32'h55667788);
        checkOutput("sw_we_cyc", 32'(we_cyc), 32'd1);
        checkOutput("sw_done_cyc", 32'(done_cyc), 32'd2);
        checkOutput("sw_mem", mem[16], 32'h55667788);

        applyStimulus(1'b1, T_W, 1'b0, 32'h42, 32'hDEADBEEF);
        checkOutput("sw_mis_done_cyc", 32'(done_cyc), 32'd1);
        checkOutput("sw_mis_err", 32'(err_seen), 32'd1);
        checkOutput("sw_mis_we", 32'(we_cnt), 32'd0);
        checkOutput("sw_mis_mem", mem[16], 32'h55667788);
        applyStimulus(1'b0, T_H, 1'b1, 32'h41, 32'h0);
        checkOutput("lh_mis_done_cyc", 32'(done_cyc), 32'd1);
        checkOutput("lh_mis_err", 32'(err_seen), 32'd1);
        checkOutput("lh_mis_rdata", oRData, 32'hAABBCCDD);

        // Reset lands while the RMW store sits in RDW.
        preload(32'hAABBCCDD);
        @(negedge clk);
        iReq = 1'b1; iWe = 1'b1; iType = T_B; iSigned = 1'b0; iAddr = 32'h41; iWData = 32'h99;
        @(posedge clk);
        #1 iReq = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we_cnt = 0;
        extra  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("rstw_ready", 32'(oReady), 32'd1);
            if (oMemWe) we_cnt++;
            if (oDone) extra++;
        end
        checkOutput("rstw_we", 32'(we_cnt), 32'd0);
        checkOutput("rstw_done", 32'(extra), 32'd0);
        checkOutput("rstw_mem", mem[16], 32'hAABBCCDD);
        checkOutput("rstw_rdata", oRData, 32'h0);

        // iReq held high across alternating word stores and loads.
        op_we   = '{1'b1, 1'b0, 1'b1, 1'b0};
        op_data = '{32'h11111111, 32'h0, 32'h22222222, 32'h0};
        issued = 0; completed = 0; b2b_we = 0;
        for (int c = 0; c < 60 && completed < 4; c++) begin
            @(negedge clk);
            if (oMemWe) b2b_we++;
            if (oDone) begin
                if (!op_we[completed])
                    checkOutput($sformatf("b2b_lw%0d", completed), oRData, op_data[completed-1]);
                completed++;
            end
            if (oReady) begin
                if (issued < 4) begin
                    iReq = 1'b1; iWe = op_we[issued]; iType = T_W; iSigned = 1'b0;
                    iAddr = 32'h40; iWData = op_data[issued];
                    issued++;
                end else begin
                    iReq = 1'b0;
                end
            end
        end
        iReq = 1'b0;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (oDone) extra++;
            if (oMemWe) b2b_we++;
        end
        checkOutput("b2b_completed", 32'(completed), 32'd4);
        checkOutput("b2b_extra_done", 32'(extra), 32'd0);
        checkOutput("b2b_we_pulses", 32'(b2b_we), 32'd2);
        checkOutput("b2b_mem", mem[16], 32'h22222222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
